// File: rtl/mem_bus_ctrl_pkg.sv
// Shared FSM type, status bit positions and register offsets for mem_bus_ctrl.
package mem_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int STATUS_READY_BIT   = 15;
   localparam int STATUS_OVERRUN_BIT = 14;

   // Each channel occupies two words: status at even offset, data at odd.
   localparam logic OFS_STATUS = 1'b0;
   localparam logic OFS_DATA   = 1'b1;

endpackage

// File: rtl/mmio_channel.sv
// One MMIO channel: captured input word with ready/overrun flags, plus an output register.
module mmio_channel
   import mem_bus_ctrl_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] io_in,
   input  logic              io_in_valid,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd_clr,
   output logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] status,
   output logic [DATA_W-1:0] io_out
);

   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] io_out_q, io_out_d;
   logic              ready_q, ready_d;
   logic              ovr_q, ovr_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      data_d   = data_q;
      io_out_d = io_out_q;
      ready_d  = ready_q & ~rd_clr;
      ovr_d    = ovr_q & ~rd_clr;
      // A capture in the same cycle as a clearing read wins over the clear.
      if (io_in_valid) begin
         ovr_d   = ovr_d | ready_d;
         ready_d = 1'b1;
         data_d  = io_in;
      end
      if (wr_en) begin
         io_out_d = wdata;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (reset) begin
         data_q   <= '0;
         io_out_q <= '0;
         ready_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         data_q   <= data_d;
         io_out_q <= io_out_d;
         ready_q  <= ready_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      status                     = '0;
      status[STATUS_READY_BIT]   = ready_q;
      status[STATUS_OVERRUN_BIT] = ovr_q;
   end

   assign data   = data_q;
   assign io_out = io_out_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-port bus controller: wait-stated RAM plus NUM_IO MMIO channels.
// Optional RAM write protection below PROT_LIMIT when MEM_BUS_CTRL_WPROT_EN is defined.
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 16,
   parameter int                RAM_AW      = 12,
   parameter int                WAIT_STATES = 2,
   parameter int                NUM_IO      = 4,
   parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFE00
`ifdef MEM_BUS_CTRL_WPROT_EN
   ,parameter logic [ADDR_W-1:0] PROT_LIMIT = 16'h0200
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic                     req_we,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic                     req_ready,
   output logic                     rsp_valid,
   output logic                     rsp_err,
   output logic [DATA_W-1:0]        rsp_rdata,
   input  logic [NUM_IO*DATA_W-1:0] io_in,
   input  logic [NUM_IO-1:0]        io_in_valid,
   output logic [NUM_IO*DATA_W-1:0] io_out
);

   localparam int                RAM_WORDS = 1 << RAM_AW;
   localparam logic [3:0]        W_LAST    = 4'(WAIT_STATES);
   localparam logic [ADDR_W-1:0] IO_SPAN   = ADDR_W'(2 * NUM_IO);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [RAM_AW-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [DATA_W-1:0] ram [RAM_WORDS];
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;

   logic              is_ram, is_io, io_is_data, prot;
   logic [ADDR_W-1:0] io_off;
   logic [2:0]        io_ch;

   logic [DATA_W-1:0] ch_data   [NUM_IO];
   logic [DATA_W-1:0] ch_status [NUM_IO];
   logic [NUM_IO-1:0] ch_wr, ch_clr;
   logic [DATA_W-1:0] io_rd_word;

   // Full-width decode: RAM first, then the MMIO window, anything else is unmapped.
   assign is_ram     = (req_addr >> RAM_AW) == '0;
   assign io_off     = req_addr - IO_BASE;
   assign is_io      = !is_ram && (req_addr >= IO_BASE) && (io_off < IO_SPAN);
   assign io_ch      = io_off[3:1];
   assign io_is_data = (io_off[0] == OFS_DATA);

`ifdef MEM_BUS_CTRL_WPROT_EN
   assign prot = req_we && (req_addr < PROT_LIMIT);
`else
   assign prot = 1'b0;
`endif

   always_comb begin
      ch_wr      = '0;
      ch_clr     = '0;
      io_rd_word = '0;
      for (int i = 0; i < NUM_IO; i++) begin
         if (io_ch == 3'(i)) begin
            ch_wr[i]   = (state_q == IDLE) && req_valid && is_io && io_is_data && req_we;
            ch_clr[i]  = (state_q == IDLE) && req_valid && is_io && io_is_data && !req_we;
            io_rd_word = (io_off[0] == OFS_STATUS) ? ch_status[i] : ch_data[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_IO; g++) begin : g_ch
      mmio_channel #(.DATA_W(DATA_W)) u_ch (
         .clk         (clk),
         .reset       (reset),
         .io_in       (io_in[g*DATA_W +: DATA_W]),
         .io_in_valid (io_in_valid[g]),
         .wr_en       (ch_wr[g]),
         .wdata       (req_wdata),
         .rd_clr      (ch_clr[g]),
         .data        (ch_data[g]),
         .status      (ch_status[g]),
         .io_out      (io_out[g*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      ram_we    = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr[RAM_AW-1:0];
               wr_d    = req_we;
               wdata_d = req_wdata;
               err_d   = 1'b0;
               rdata_d = '0;
               if (is_ram) begin
                  err_d = prot;
                  if (WAIT_STATES == 0) begin
                     ram_addr  = req_addr[RAM_AW-1:0];
                     ram_wdata = req_wdata;
                     ram_we    = req_we && !prot;
                     rdata_d   = req_we ? '0 : ram[ram_addr];
                     state_d   = RESP;
                  end else begin
                     cnt_d   = 4'd1;
                     state_d = WAIT;
                  end
               end else if (is_io) begin
                  rdata_d = req_we ? '0 : io_rd_word;
                  err_d   = req_we && !io_is_data;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == W_LAST) begin
               ram_we  = wr_q && !err_q;
               rdata_d = wr_q ? '0 : ram[addr_q];
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // NOTE: the RAM array is deliberately not reset; reset only blocks a write on the same edge.
   always_ff @(posedge clk) begin
      if (ram_we && !reset) begin
         ram[ram_addr] <= ram_wdata;
      end
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      rsp_err   = rsp_valid && err_q;
      rsp_rdata = rsp_valid ? rdata_q : '0;
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl (default parameters).
module tb_mem_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        req_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_rdata;
   logic [63:0] io_in;
   logic [3:0]  io_in_valid;
   logic [63:0] io_out;

   int checks = 0;
   int errors = 0;

   mem_bus_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_rdata   (rsp_rdata),
      .io_in       (io_in),
      .io_in_valid (io_in_valid),
      .io_out      (io_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issues one request from an IDLE cycle (#1 after an edge) and returns at the
   // response cycle; then confirms the response lasted one cycle and IDLE returned.
   task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic cap, input logic [15:0] cap_val,
                         output int lat, output logic [15:0] rdata, output logic err);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      if (cap) begin
         io_in[15:0]    = cap_val;
         io_in_valid[0] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      io_in_valid = '0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk); #1;
      check({tag, " one_cycle"}, {62'd0, rsp_valid, req_ready}, 64'b01);
   endtask

   task automatic req_chk(input string tag, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic cap, input logic [15:0] cap_val,
                          input int exp_lat, input logic [15:0] exp_rdata, input logic exp_err);
      int          lat;
      logic [15:0] rdata;
      logic        err;
      do_req(tag, we, addr, wdata, cap, cap_val, lat, rdata, err);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " rdata"}, 64'(rdata), 64'(exp_rdata));
      check({tag, " err"}, 64'(err), 64'(exp_err));
   endtask

   task automatic pulse(input int ch, input logic [15:0] val);
      io_in[ch*16 +: 16] = val;
      io_in_valid[ch]    = 1'b1;
      @(posedge clk); #1;
      io_in_valid = '0;
   endtask

   initial begin
      logic        seen;
`ifdef MEM_BUS_CTRL_WPROT_EN
      int          lat;
      logic [15:0] prior;
      logic        err;
`endif
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      io_in       = '0;
      io_in_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_err", 64'(rsp_err), 64'd0);
      check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("reset io_out", io_out, 64'd0);
      reset = 1'b0;

      // RAM write/read with two wait states, plus the last RAM word and first address past it.
      req_chk("ram_wr_0300", 1'b1, 16'h0300, 16'h1234, 1'b0, 16'h0, 3, 16'h0000, 1'b0);
      req_chk("ram_rd_0300", 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0, 3, 16'h1234, 1'b0);
      req_chk("ram_wr_0fff", 1'b1, 16'h0FFF, 16'hA5C3, 1'b0, 16'h0, 3, 16'h0000, 1'b0);
      req_chk("ram_rd_0fff", 1'b0, 16'h0FFF, 16'h0000, 1'b0, 16'h0, 3, 16'hA5C3, 1'b0);
      req_chk("rd_1000_unmapped", 1'b0, 16'h1000, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b1);
      req_chk("ram_rd_0300_again", 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0, 3, 16'h1234, 1'b0);

      // Channel 0 capture, overrun, clearing read.
      req_chk("rd_fe01_empty", 1'b0, 16'hFE01, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b0);
      pulse(0, 16'h00AB);
      pulse(0, 16'h00AB);
      req_chk("rd_fe00_overrun", 1'b0, 16'hFE00, 16'h0000, 1'b0, 16'h0, 1, 16'hC000, 1'b0);
      req_chk("rd_fe01_data", 1'b0, 16'hFE01, 16'h0000, 1'b0, 16'h0, 1, 16'h00AB, 1'b0);
      req_chk("rd_fe00_cleared", 1'b0, 16'hFE00, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b0);

      // Channel 2 single capture: ready only.
      pulse(2, 16'h0042);
      req_chk("rd_fe04_ready", 1'b0, 16'hFE04, 16'h0000, 1'b0, 16'h0, 1, 16'h8000, 1'b0);
      req_chk("rd_fe05_data", 1'b0, 16'hFE05, 16'h0000, 1'b0, 16'h0, 1, 16'h0042, 1'b0);

      // Output register write and status-write rejection on channel 1.
      req_chk("wr_fe03", 1'b1, 16'hFE03, 16'h5A5A, 1'b0, 16'h0, 1, 16'h0000, 1'b0);
      check("io_out1 after wr_fe03", 64'(io_out[31:16]), 64'h5A5A);
      check("io_out0 untouched", 64'(io_out[15:0]), 64'h0000);
      req_chk("wr_fe02_status", 1'b1, 16'hFE02, 16'h1111, 1'b0, 16'h0, 1, 16'h0000, 1'b1);
      check("io_out1 after wr_fe02", 64'(io_out[31:16]), 64'h5A5A);

      // Unmapped edges of the MMIO window and the last valid channel register.
      req_chk("rd_2000_unmapped", 1'b0, 16'h2000, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b1);
      req_chk("rd_fdff_unmapped", 1'b0, 16'hFDFF, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b1);
      req_chk("rd_fe08_unmapped", 1'b0, 16'hFE08, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b1);
      req_chk("rd_fe07_ch3", 1'b0, 16'hFE07, 16'h0000, 1'b0, 16'h0, 1, 16'h0000, 1'b0);

      // Clearing read colliding with a new capture: old word returned, capture wins.
      req_chk("rd_fe01_collide", 1'b0, 16'hFE01, 16'h0000, 1'b1, 16'h0077, 1, 16'h00AB, 1'b0);
      req_chk("rd_fe00_after_collide", 1'b0, 16'hFE00, 16'h0000, 1'b0, 16'h0, 1, 16'h8000, 1'b0);
      req_chk("rd_fe01_new_word", 1'b0, 16'hFE01, 16'h0000, 1'b0, 16'h0, 1, 16'h0077, 1'b0);

      // Reset during cycle 1 of a RAM write aborts it.
      req_chk("ram_wr_0400", 1'b1, 16'h0400, 16'h1111, 1'b0, 16'h0, 3, 16'h0000, 1'b0);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 16'h0400;
      req_wdata = 16'hBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      check("abort busy", 64'(req_ready), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort ready", 64'(req_ready), 64'd1);
      seen = 1'b0;
      repeat (6) begin
         if (rsp_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      check("abort no rsp", 64'(seen), 64'd0);
      check("abort io_out cleared", io_out, 64'd0);
      req_chk("ram_rd_0400", 1'b0, 16'h0400, 16'h0000, 1'b0, 16'h0, 3, 16'h1111, 1'b0);

`ifdef MEM_BUS_CTRL_WPROT_EN
      do_req("wprot_rd_prior", 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0, lat, prior, err);
      req_chk("wprot_wr_0100", 1'b1, 16'h0100, 16'hBEEF, 1'b0, 16'h0, 3, 16'h0000, 1'b1);
      req_chk("wprot_rd_0100", 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0, 3, prior ^ 16'h0000, 1'b0);
      req_chk("wprot_wr_0200", 1'b1, 16'h0200, 16'h7E57, 1'b0, 16'h0, 3, 16'h0000, 1'b0);
      req_chk("wprot_rd_0200", 1'b0, 16'h0200, 16'h0000, 1'b0, 16'h0, 3, 16'h7E57, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: request address width.
REQ-002 Parameter DATA_W, default 16: data word width.
REQ-003 Parameter RAM_AW, default 12: RAM holds 2**RAM_AW words at addresses 0..2**RAM_AW-1.
REQ-004 Parameter WAIT_STATES, default 2, range 0..15: extra cycles per RAM access.
REQ-005 Parameter NUM_IO, default 4, range 1..8: number of MMIO channels.
REQ-006 Parameter IO_BASE, default 16'hFE00: channel i status at IO_BASE+2i, data at IO_BASE+2i+1.
REQ-007 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-008 Port reset  input  1: synchronous, active-high reset.
REQ-009 Ports req_valid / req_we  input  1 each: request present / request is a write.
REQ-010 Ports req_addr  input  ADDR_W and req_wdata  input  DATA_W: address and write data.
REQ-011 Port req_ready  output  1: request accepted on an edge where req_valid and req_ready are both high.
REQ-012 Ports rsp_valid / rsp_err  output  1 each, and rsp_rdata  output  DATA_W: one-cycle response.
REQ-013 Ports io_in  input  NUM_IO*DATA_W and io_in_valid  input  NUM_IO: per-channel input word and its capture strobe.
REQ-014 Port io_out  output  NUM_IO*DATA_W: per-channel output registers.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready high only in IDLE.
REQ-016 RAM access, accepted in cycle 0: WAIT for WAIT_STATES cycles (1..W); write commits and read data latches at end of cycle W (cycle 0 if W=0); rsp_valid in cycle W+1.
REQ-017 MMIO and unmapped access: skip WAIT, effect at end of cycle 0, rsp_valid in cycle 1.
REQ-018 rsp_valid lasts exactly one cycle, no backpressure; the FSM returns to IDLE the next cycle (max throughput 1 request per W+2 cycles).
REQ-019 rsp_rdata is valid only with rsp_valid, zero for writes; rsp_err is zero unless REQ-020/021/029 apply.
REQ-020 Unmapped address (not RAM, not a channel register): rsp_err=1, rsp_rdata=0, no state change.
REQ-021 Write to a status register: ignored, rsp_err=1.
REQ-022 Write to channel i data register: io_out[i] takes req_wdata.
REQ-023 io_in_valid[i] high: capture io_in[i] into data register i and set ready (status bit 15); if ready was already set, also set overrun (bit 14); all other status bits read 0.
REQ-024 Read of channel i data register returns the captured word, then clears ready and overrun.
REQ-025 Capture and clearing read of the same channel in the same cycle: read returns the old word, and the capture wins (ready=1, overrun unchanged from clear, i.e. 0).
REQ-026 Addresses are compared at full ADDR_W width; no aliasing or wrap-around.

Reset
REQ-027 Reset forces IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, io_out=0, all ready, overrun and captured data=0; RAM contents are not reset.
REQ-028 Reset before the commit edge of an in-flight access aborts it: no RAM write, no response.

Configuration
REQ-029 Macro MEM_BUS_CTRL_WPROT_EN defined: parameter PROT_LIMIT (default 16'h0200) is added, and RAM writes below PROT_LIMIT are not performed and return rsp_err=1 with normal RAM latency.
REQ-030 Macro MEM_BUS_CTRL_WPROT_EN undefined: no PROT_LIMIT parameter, and all RAM writes are performed.

Structure
REQ-031 Package mem_bus_ctrl_pkg holds the FSM state typedef, the status bit positions (READY=15, OVERRUN=14), and the status/data offset constants.
REQ-032 Sub-module mmio_channel, instantiated NUM_IO times, holds one channel's data, ready, overrun and io_out registers.

Verification
REQ-033 Default params, write 16'h1234 to 16'h0300, then read it -> both responses arrive 3 cycles after acceptance; rsp_rdata=16'h1234, rsp_err=0.
REQ-034 Read 16'hFE01 with no capture -> rsp_valid at cycle 1, rdata=0; pulse io_in_valid[0] with 16'h00AB twice, read 16'hFE00 -> 16'hC000; read 16'hFE01 -> 16'h00AB; read 16'hFE00 -> 16'h0000.
REQ-035 Write 16'h5A5A to 16'hFE03 -> io_out[1]=16'h5A5A in cycle 1; write to 16'hFE02 -> rsp_err=1, io_out[1] unchanged.
REQ-036 Read 16'h2000 (unmapped) -> rsp_err=1, rdata=0 at cycle 1; read FE01 coinciding with a capture of 16'h0077 -> returns old word, status then reads 16'h8000.
REQ-037 Assert reset during cycle 1 of a RAM write to 16'h0400 -> no rsp_valid; a later read of 16'h0400 returns its prior value; with MEM_BUS_CTRL_WPROT_EN, a write to 16'h0100 -> rsp_err=1 and the word is unchanged.
